// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// wb_port_arbiter : shares the RF write port between the W stage and MDU FIFO.
// Optional feature macro: WB_PEND_MASK_EN (adds PendMask output).
// Rev 1.0
// ============================================================================
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        MduValid,
   input  logic [4:0]  MduRd,
   input  logic [31:0] MduResult,
   output logic        MduReady,
   output logic        RfWE,
   output logic [4:0]  RfA3,
   output logic [31:0] RfWD,
   output logic        StallWB
`ifdef WB_PEND_MASK_EN
   ,
   output logic [31:0] PendMask
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        age_q, age_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [4:0]        fifo_rd_q [DEPTH];
   logic [31:0]       fifo_wd_q [DEPTH];

   logic pw, fifo_empty, fifo_full, mdu_xfer, push, pop, bypass;

   always_comb begin
      pw         = RegWriteW & (RdW != 5'd0);
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_W'(DEPTH));
      MduReady   = reset_n & ~fifo_full;
      mdu_xfer   = MduValid & MduReady & (MduRd != 5'd0);

      RfWE    = 1'b0;
      RfA3    = 5'd0;
      RfWD    = 32'd0;
      StallWB = 1'b0;
      pop     = 1'b0;
      bypass  = 1'b0;
      age_d   = age_q;

      if (reset_n) begin
         if (state_q == ST_FORCE) begin
            RfWE    = 1'b1;
            RfA3    = fifo_rd_q[rd_ptr_q];
            RfWD    = fifo_wd_q[rd_ptr_q];
            StallWB = pw;
            pop     = 1'b1;
         end else if (pw) begin
            RfWE = 1'b1;
            RfA3 = RdW;
            RfWD = ResultW;
            if (!fifo_empty) age_d = age_q + 4'd1;
         end else if (!fifo_empty) begin
            RfWE = 1'b1;
            RfA3 = fifo_rd_q[rd_ptr_q];
            RfWD = fifo_wd_q[rd_ptr_q];
            pop  = 1'b1;
         end else if (mdu_xfer) begin
            // Empty FIFO and idle port: write the MDU result straight through
            RfWE   = 1'b1;
            RfA3   = MduRd;
            RfWD   = MduResult;
            bypass = 1'b1;
         end
      end

      if (pop) age_d = 4'd0;
      push = mdu_xfer & ~bypass;

      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

      if (count_d == '0)                 state_d = ST_IDLE;
      else if (age_d == 4'(MAX_WAIT))    state_d = ST_FORCE;
      else                               state_d = ST_WAIT;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         age_q    <= 4'd0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         age_q    <= age_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q] <= MduRd;
         fifo_wd_q[wr_ptr_q] <= MduResult;
      end
   end

`ifdef WB_PEND_MASK_EN
   logic [31:0]      pend_d, pend_q;
   logic [PTR_W-1:0] offs;
   logic [4:0]       ent_rd;

   // Rebuilt from next-cycle occupancy so duplicate rds are never cleared early
   always_comb begin
      pend_d = 32'd0;
      offs   = '0;
      ent_rd = 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
         offs   = PTR_W'(i) - rd_ptr_d;
         ent_rd = (push && (PTR_W'(i) == wr_ptr_q)) ? MduRd : fifo_rd_q[i];
         if (CNT_W'(offs) < count_d) pend_d[ent_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) pend_q <= 32'd0;
      else          pend_q <= pend_d;
   end

   assign PendMask = pend_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_wb_port_arbiter : directed scenarios plus randomized queue-model checking.
// Rev 1.0
// ============================================================================
module tb_wb_port_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
   logic        MduValid;
   logic [4:0]  MduRd;
   logic [31:0] MduResult;
   logic        MduReady;
   logic        RfWE;
   logic [4:0]  RfA3;
   logic [31:0] RfWD;
   logic        StallWB;
`ifdef WB_PEND_MASK_EN
   logic [31:0] PendMask;
`endif

   wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .RegWriteW (RegWriteW),
      .RdW       (RdW),
      .ResultW   (ResultW),
      .MduValid  (MduValid),
      .MduRd     (MduRd),
      .MduResult (MduResult),
      .MduReady  (MduReady),
      .RfWE      (RfWE),
      .RfA3      (RfA3),
      .RfWD      (RfWD),
      .StallWB   (StallWB)
`ifdef WB_PEND_MASK_EN
      ,
      .PendMask  (PendMask)
`endif
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: an ordered list of pending MDU results and the head's age
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] wd;
   } ent_t;
   ent_t mq[$];
   int   m_age;
   logic e_we, e_stall, e_ready, m_pop, m_push, m_pw;
   logic [4:0]  e_a3;
   logic [31:0] e_wd;
   logic [31:0] e_mask;

   task automatic model_expect();
      logic accept;
      m_pw    = RegWriteW && (RdW != 5'd0);
      e_ready = reset_n && (mq.size() < DEPTH);
      accept  = MduValid && e_ready && (MduRd != 5'd0);
      e_we = 1'b0; e_a3 = 5'd0; e_wd = 32'd0; e_stall = 1'b0;
      m_pop = 1'b0; m_push = 1'b0;
      e_mask = 32'd0;
      foreach (mq[k]) e_mask[mq[k].rd] = 1'b1;
      if (reset_n) begin
         if (mq.size() > 0 && m_age == MAX_WAIT) begin
            e_we = 1'b1; e_a3 = mq[0].rd; e_wd = mq[0].wd; e_stall = m_pw; m_pop = 1'b1;
         end else if (m_pw) begin
            e_we = 1'b1; e_a3 = RdW; e_wd = ResultW;
         end else if (mq.size() > 0) begin
            e_we = 1'b1; e_a3 = mq[0].rd; e_wd = mq[0].wd; m_pop = 1'b1;
         end else if (accept) begin
            e_we = 1'b1; e_a3 = MduRd; e_wd = MduResult;
         end
         m_push = accept && !(mq.size() == 0 && !m_pw);
      end
   endtask

   task automatic model_commit();
      if (!reset_n) begin
         mq.delete();
         m_age = 0;
      end else begin
         if (m_pop) begin
            void'(mq.pop_front());
            m_age = 0;
         end else if (m_pw && mq.size() > 0) begin
            m_age++;
         end
         if (m_push) mq.push_back('{rd: MduRd, wd: MduResult});
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
      MduValid = 1'b0; MduRd = 5'd0; MduResult = 32'd0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
      mq.delete();
      m_age = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h55;
      MduValid = 1'b1; MduRd = 5'd2; MduResult = 32'h22;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++; if (RfWE !== 1'b0)     begin n_fail++; $display("FAIL reset_we got=%b exp=0", RfWE); end
         n_vec++; if (MduReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", MduReady); end
         n_vec++; if (StallWB !== 1'b0)  begin n_fail++; $display("FAIL reset_stall got=%b exp=0", StallWB); end
         next_cycle();
      end
      apply_reset();
   endtask

   task automatic test_bypass();
      idle_inputs();
      MduValid = 1'b1; MduRd = 5'd7; MduResult = 32'h1234;
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b1)        begin n_fail++; $display("FAIL bypass_we got=%b exp=1", RfWE); end
      n_vec++; if (RfA3 !== 5'd7)        begin n_fail++; $display("FAIL bypass_a3 got=%0d exp=7", RfA3); end
      n_vec++; if (RfWD !== 32'h1234)    begin n_fail++; $display("FAIL bypass_wd got=%h exp=1234", RfWD); end
      n_vec++; if (MduReady !== 1'b1)    begin n_fail++; $display("FAIL bypass_ready got=%b exp=1", MduReady); end
      next_cycle();
      idle_inputs();
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b0)        begin n_fail++; $display("FAIL bypass_not_queued got=%b exp=0", RfWE); end
      next_cycle();
      apply_reset();
   endtask

   task automatic test_starve();
      RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'hA0;
      MduValid = 1'b1; MduRd = 5'd3; MduResult = 32'h333;
      @(negedge clk);
      n_vec++; if (RfA3 !== 5'd10) begin n_fail++; $display("FAIL starve_push_a3 got=%0d exp=10", RfA3); end
      next_cycle();
      MduValid = 1'b0; RdW = 5'd9;
      for (int k = 0; k < MAX_WAIT; k++) begin
         ResultW = 32'h900 + k;
         @(negedge clk);
         n_vec++; if (RfA3 !== 5'd9 || RfWD !== 32'h900 + k)
            begin n_fail++; $display("FAIL starve_w_wins[%0d] got a3=%0d wd=%h exp a3=9", k, RfA3, RfWD); end
         n_vec++; if (StallWB !== 1'b0) begin n_fail++; $display("FAIL starve_nostall[%0d] got=%b exp=0", k, StallWB); end
         next_cycle();
      end
      ResultW = 32'h9FF;
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b1 || RfA3 !== 5'd3 || RfWD !== 32'h333)
         begin n_fail++; $display("FAIL starve_force got we=%b a3=%0d wd=%h exp we=1 a3=3 wd=333", RfWE, RfA3, RfWD); end
      n_vec++; if (StallWB !== 1'b1) begin n_fail++; $display("FAIL starve_stall got=%b exp=1", StallWB); end
      next_cycle();
      @(negedge clk);
      n_vec++; if (RfA3 !== 5'd9 || RfWD !== 32'h9FF || StallWB !== 1'b0)
         begin n_fail++; $display("FAIL starve_retry got a3=%0d wd=%h stall=%b exp a3=9 wd=9ff stall=0", RfA3, RfWD, StallWB); end
      next_cycle();
      apply_reset();
   endtask

   task automatic test_full();
      RegWriteW = 1'b1; RdW = 5'd21; ResultW = 32'h2100;
      MduValid = 1'b1; MduRd = 5'd11; MduResult = 32'hB11;
      @(negedge clk);
      n_vec++; if (MduReady !== 1'b1) begin n_fail++; $display("FAIL full_ready0 got=%b exp=1", MduReady); end
      next_cycle();
      MduRd = 5'd12; MduResult = 32'hB12;
      @(negedge clk);
      n_vec++; if (MduReady !== 1'b1) begin n_fail++; $display("FAIL full_ready1 got=%b exp=1", MduReady); end
      next_cycle();
      MduRd = 5'd13; MduResult = 32'hB13;
      @(negedge clk);
      n_vec++; if (MduReady !== 1'b0) begin n_fail++; $display("FAIL full_ready_low got=%b exp=0", MduReady); end
      next_cycle();
      RegWriteW = 1'b0;
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b1 || RfA3 !== 5'd11 || RfWD !== 32'hB11)
         begin n_fail++; $display("FAIL full_pop_head got we=%b a3=%0d wd=%h exp a3=11 wd=b11", RfWE, RfA3, RfWD); end
      n_vec++; if (MduReady !== 1'b0) begin n_fail++; $display("FAIL full_ready_same_cycle got=%b exp=0", MduReady); end
      next_cycle();
      @(negedge clk);
      n_vec++; if (MduReady !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%b exp=1", MduReady); end
      n_vec++; if (RfA3 !== 5'd12 || RfWD !== 32'hB12)
         begin n_fail++; $display("FAIL full_order got a3=%0d wd=%h exp a3=12 wd=b12", RfA3, RfWD); end
      next_cycle();
      MduValid = 1'b0;
      @(negedge clk);
      n_vec++; if (RfA3 !== 5'd13 || RfWD !== 32'hB13)
         begin n_fail++; $display("FAIL full_last got a3=%0d wd=%h exp a3=13 wd=b13", RfA3, RfWD); end
      next_cycle();
      apply_reset();
   endtask

   task automatic test_x0();
      RegWriteW = 1'b1; RdW = 5'd8; ResultW = 32'h88;
      MduValid = 1'b1; MduRd = 5'd4; MduResult = 32'h444;
      next_cycle();
      RdW = 5'd0; MduValid = 1'b0;
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b1 || RfA3 !== 5'd4 || RfWD !== 32'h444)
         begin n_fail++; $display("FAIL x0_head_drains got we=%b a3=%0d wd=%h exp a3=4 wd=444", RfWE, RfA3, RfWD); end
      n_vec++; if (StallWB !== 1'b0) begin n_fail++; $display("FAIL x0_nostall got=%b exp=0", StallWB); end
      next_cycle();
      RegWriteW = 1'b0; MduValid = 1'b1; MduRd = 5'd0; MduResult = 32'hDEAD;
      @(negedge clk);
      n_vec++; if (MduReady !== 1'b1 || RfWE !== 1'b0)
         begin n_fail++; $display("FAIL x0_mdu_drop got ready=%b we=%b exp ready=1 we=0", MduReady, RfWE); end
      next_cycle();
      MduValid = 1'b0;
      @(negedge clk);
      n_vec++; if (RfWE !== 1'b0) begin n_fail++; $display("FAIL x0_never_written got=%b exp=0", RfWE); end
      next_cycle();
      apply_reset();
   endtask

`ifdef WB_PEND_MASK_EN
   task automatic test_pend_mask();
      RegWriteW = 1'b1; RdW = 5'd10; ResultW = 32'h1;
      MduValid = 1'b1; MduRd = 5'd6; MduResult = 32'h666;
      next_cycle();
      RegWriteW = 1'b0; MduValid = 1'b0;
      @(negedge clk);
      n_vec++; if (PendMask !== 32'h40) begin n_fail++; $display("FAIL pend_set got=%h exp=00000040", PendMask); end
      next_cycle();
      @(negedge clk);
      n_vec++; if (PendMask !== 32'h0) begin n_fail++; $display("FAIL pend_clear got=%h exp=0", PendMask); end
      next_cycle();
      apply_reset();
   endtask
`endif

   task automatic test_random(input int ncyc);
      logic hold_w, hold_mdu;
      apply_reset();
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         model_expect();
         n_vec++; if (RfWE !== e_we) begin n_fail++; $display("FAIL rnd_we[%0d] got=%b exp=%b", c, RfWE, e_we); end
         if (e_we) begin
            n_vec++; if (RfA3 !== e_a3 || RfWD !== e_wd)
               begin n_fail++; $display("FAIL rnd_data[%0d] got a3=%0d wd=%h exp a3=%0d wd=%h", c, RfA3, RfWD, e_a3, e_wd); end
         end
         n_vec++; if (StallWB !== e_stall) begin n_fail++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", c, StallWB, e_stall); end
         n_vec++; if (MduReady !== e_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", c, MduReady, e_ready); end
`ifdef WB_PEND_MASK_EN
         n_vec++; if (PendMask !== e_mask) begin n_fail++; $display("FAIL rnd_mask[%0d] got=%h exp=%h", c, PendMask, e_mask); end
`endif
         hold_w   = reset_n && e_stall;
         hold_mdu = reset_n && MduValid && !e_ready;
         model_commit();
         next_cycle();
         reset_n = ($urandom_range(0, 199) != 0);
         if (!hold_w) begin
            RegWriteW = ($urandom_range(0, 9) < 7);
            RdW       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ResultW   = $urandom;
         end
         if (!hold_mdu) begin
            MduValid  = ($urandom_range(0, 9) < 4);
            MduRd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MduResult = $urandom;
         end
      end
      apply_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

   initial begin
      m_age = 0;
      idle_inputs();
      reset_n = 1'b0;
      next_cycle();
      test_reset();
      test_bypass();
      test_starve();
      test_full();
      test_x0();
`ifdef WB_PEND_MASK_EN
      test_pend_mask();
`endif
      test_random(3000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
